// File: rtl/clk_en_gen.sv
// -----------------------------------------------------------------------------
// clk_en_gen
// Multi-channel fractional clock-enable generator. Each channel runs a
// phase accumulator (DDS). A channel emits a one-cycle enable strobe whenever
// its accumulator wraps, so the average strobe rate is inc / 2^ACC_W per clk.
// All strobes are in the clk domain, so no derived clock nets are needed.
//
// Increments are reprogrammed at runtime:
//   - On a disabled channel a write loads the increment immediately.
//   - On a running channel a write is parked in a pending register. It is
//     applied on the next wrap, so the period in progress always completes
//     with the old increment and no short or long period is ever produced.
//
// Parameters:
//   NCHAN  - number of independent channels (1..16)
//   ACC_W  - accumulator / increment width in bits
//   CHAN_W - width of the write channel select (2^CHAN_W >= NCHAN)
//
// Ports:
//   clk      in   system clock, the only clock of the block
//   reset_n  in   asynchronous active-low reset
//   chan_en  in   [NCHAN]  per-channel run enable
//   wr_en    in   increment write strobe (single cycle)
//   wr_chan  in   [CHAN_W] target channel; values >= NCHAN are ignored
//   wr_data  in   [ACC_W]  new increment value
//   sync_in  in   (only with CLK_EN_GEN_SYNC_EN) phase-align all channels
//   ce       out  [NCHAN]  registered one-cycle enable strobes
//   pending  out  [NCHAN]  channel holds a written increment not yet applied
//
// Build option:
//   CLK_EN_GEN_SYNC_EN - when defined, adds sync_in. An edge with sync_in=1
//   clears every enabled accumulator instead of adding, suppresses ce for
//   that edge and applies any pending increment as if the channel wrapped.
//   Without it the port does not exist and channels align only via chan_en.
// -----------------------------------------------------------------------------
module clk_en_gen #(
  parameter int NCHAN  = 4,
  parameter int ACC_W  = 24,
  parameter int CHAN_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCHAN-1:0]  chan_en,
  input  logic              wr_en,
  input  logic [CHAN_W-1:0] wr_chan,
  input  logic [ACC_W-1:0]  wr_data,
`ifdef CLK_EN_GEN_SYNC_EN
  input  logic              sync_in,
`endif
  output logic [NCHAN-1:0]  ce,
  output logic [NCHAN-1:0]  pending
);

  // Elaboration-time parameter sanity.
  if (NCHAN < 1 || NCHAN > 16) begin : g_bad_nchan
    $error("clk_en_gen: NCHAN must be in 1..16");
  end
  if ((1 << CHAN_W) < NCHAN) begin : g_bad_chan_w
    $error("clk_en_gen: CHAN_W too narrow for NCHAN");
  end

  // Phase-alignment request shared by all channels.
  logic w_sync;
`ifdef CLK_EN_GEN_SYNC_EN
  assign w_sync = sync_in;
`else
  assign w_sync = 1'b0;
`endif

  // Write decode. A select value >= NCHAN matches no channel and is dropped.
  logic [NCHAN-1:0] w_wr_hit;

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan

    assign w_wr_hit[gi] = wr_en && (wr_chan == CHAN_W'(gi));

    // Per-channel state.
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_pend_val;
    logic             r_pend;
    logic             r_ce;

    // Next-state values.
    logic [ACC_W-1:0] w_acc_nxt;
    logic [ACC_W-1:0] w_inc_nxt;
    logic [ACC_W-1:0] w_pend_val_nxt;
    logic             w_pend_nxt;
    logic             w_ce_nxt;
    logic             w_apply;

    // One extra bit holds the wrap carry; the low ACC_W bits wrap naturally.
    logic [ACC_W:0]   w_sum;
    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

    always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the branches below can leave it unassigned and infer a latch.
      w_acc_nxt      = r_acc;
      w_inc_nxt      = r_inc;
      w_pend_val_nxt = r_pend_val;
      w_pend_nxt     = r_pend;
      w_ce_nxt       = 1'b0;
      w_apply        = 1'b0;

      if (!chan_en[gi]) begin
        // Idle channel: hold phase at zero so the next enable starts with a
        // deterministic phase. A parked increment has no period to protect,
        // so it is applied right away; a fresh write takes priority over it.
        w_acc_nxt = '0;
        if (w_wr_hit[gi]) begin
          w_inc_nxt  = wr_data;
          w_pend_nxt = 1'b0;
        end else if (r_pend) begin
          w_inc_nxt  = r_pend_val;
          w_pend_nxt = 1'b0;
        end
      end else begin
        if (w_sync) begin
          // Forced phase alignment counts as a period boundary, without a strobe.
          w_acc_nxt = '0;
          w_apply   = 1'b1;
        end else begin
          w_acc_nxt = w_sum[ACC_W-1:0];
          w_ce_nxt  = w_sum[ACC_W];
          w_apply   = w_sum[ACC_W];
        end

        // The add on this edge already used the old increment; the parked
        // value takes effect for the period that starts now.
        if (w_apply && r_pend) begin
          w_inc_nxt  = r_pend_val;
          w_pend_nxt = 1'b0;
        end

        // A write on the same edge parks the new value after the old pending
        // value has been consumed above, so nothing is lost.
        if (w_wr_hit[gi]) begin
          w_pend_val_nxt = wr_data;
          w_pend_nxt     = 1'b1;
        end
      end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        // NOTE: every per-channel register is reset, including the increment
        // and pending value, because inc=0 after reset is observable behaviour
        // (no strobes until software programs a channel).
        r_acc      <= '0;
        r_inc      <= '0;
        r_pend_val <= '0;
        r_pend     <= 1'b0;
        r_ce       <= 1'b0;
      end else begin
        r_acc      <= w_acc_nxt;
        r_inc      <= w_inc_nxt;
        r_pend_val <= w_pend_val_nxt;
        r_pend     <= w_pend_nxt;
        r_ce       <= w_ce_nxt;
      end
    end

    assign ce[gi]      = r_ce;
    assign pending[gi] = r_pend;

  end : g_chan

endmodule

// File: tb/tb_clk_en_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_en_gen
// Self-checking bench for clk_en_gen, built with NCHAN=3, ACC_W=8, CHAN_W=2 so
// that wr_chan=3 is an out-of-range channel. Combines a table of directed
// vectors, hand-written multi-cycle sequences and a randomized phase compared
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_clk_en_gen;

  localparam int NCHAN  = 3;
  localparam int ACC_W  = 8;
  localparam int CHAN_W = 2;
  localparam int MOD    = 1 << ACC_W;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCHAN-1:0]  chan_en = '0;
  logic              wr_en   = 1'b0;
  logic [CHAN_W-1:0] wr_chan = '0;
  logic [ACC_W-1:0]  wr_data = '0;
`ifdef CLK_EN_GEN_SYNC_EN
  logic              sync_in = 1'b0;
`endif
  logic [NCHAN-1:0]  ce;
  logic [NCHAN-1:0]  pending;

  clk_en_gen #(
    .NCHAN  (NCHAN),
    .ACC_W  (ACC_W),
    .CHAN_W (CHAN_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .chan_en (chan_en),
    .wr_en   (wr_en),
    .wr_chan (wr_chan),
    .wr_data (wr_data),
`ifdef CLK_EN_GEN_SYNC_EN
    .sync_in (sync_in),
`endif
    .ce      (ce),
    .pending (pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) --------------
  int             m_acc [NCHAN];
  int             m_inc [NCHAN];
  int             m_pv  [NCHAN];
  bit [NCHAN-1:0] m_pend = '0;
  bit [NCHAN-1:0] m_ce   = '0;

  task automatic model_reset();
    for (int i = 0; i < NCHAN; i++) begin
      m_acc[i] = 0;
      m_inc[i] = 0;
      m_pv[i]  = 0;
    end
    m_pend = '0;
    m_ce   = '0;
  endtask

  task automatic model_edge();
    int sum;
    bit s;
    bit hit;
    bit apply;
    s = 1'b0;
`ifdef CLK_EN_GEN_SYNC_EN
    s = sync_in;
`endif
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NCHAN; i++) begin
      hit = wr_en && (int'(wr_chan) == i);
      if (!chan_en[i]) begin
        m_acc[i] = 0;
        m_ce[i]  = 1'b0;
        if (hit) begin
          m_inc[i]  = int'(wr_data);
          m_pend[i] = 1'b0;
        end else if (m_pend[i]) begin
          m_inc[i]  = m_pv[i];
          m_pend[i] = 1'b0;
        end
      end else begin
        sum = m_acc[i] + m_inc[i];
        if (s) begin
          m_acc[i] = 0;
          m_ce[i]  = 1'b0;
          apply    = 1'b1;
        end else begin
          m_acc[i] = sum % MOD;
          m_ce[i]  = (sum >= MOD);
          apply    = m_ce[i];
        end
        if (apply && m_pend[i]) begin
          m_inc[i]  = m_pv[i];
          m_pend[i] = 1'b0;
        end
        if (hit) begin
          m_pv[i]   = int'(wr_data);
          m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  // One clock: model follows the same edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic write(input int ch, input int data);
    wr_en   = 1'b1;
    wr_chan = CHAN_W'(ch);
    wr_data = ACC_W'(data);
  endtask

  // ---------------- directed vector table -----------------------------------
  typedef struct {
    logic [NCHAN-1:0]  chan_en;
    logic              wr_en;
    logic [CHAN_W-1:0] wr_chan;
    logic [ACC_W-1:0]  wr_data;
    logic [NCHAN-1:0]  exp_ce;
    logic [NCHAN-1:0]  exp_pend;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] bits;
    int          cnt;
    int          gap;
    int          f0;
    int          f1;

    // inc=64 on ch0: enable at row 1 (edge E), strobes after E+3 and E+7.
    vecs[0]  = '{3'b000, 1'b1, 2'd0, 8'd64, 3'b000, 3'b000};
    vecs[1]  = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b000, 3'b000};
    vecs[2]  = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b000, 3'b000};
    vecs[3]  = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b000, 3'b000};
    vecs[4]  = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b001, 3'b000};
    vecs[5]  = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b000, 3'b000};
    vecs[6]  = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b000, 3'b000};
    vecs[7]  = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b000, 3'b000};
    vecs[8]  = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b001, 3'b000};
    // Write to running ch0 parks the value; disabling applies it at once.
    vecs[9]  = '{3'b001, 1'b1, 2'd0, 8'd64, 3'b000, 3'b001};
    vecs[10] = '{3'b000, 1'b0, 2'd0, 8'd0,  3'b000, 3'b000};
    // Out-of-range channel write is ignored.
    vecs[11] = '{3'b000, 1'b1, 2'd3, 8'd7,  3'b000, 3'b000};

    model_reset();

    // ---- reset state ----
    repeat (2) tick();
    #2;
    check("reset_ce", 32'(ce), 32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    reset_n = 1'b1;

    // ---- table ----
    for (int v = 0; v < 12; v++) begin
      chan_en = vecs[v].chan_en;
      wr_en   = vecs[v].wr_en;
      wr_chan = vecs[v].wr_chan;
      wr_data = vecs[v].wr_data;
      tick();
      check($sformatf("vec%0d_ce", v), 32'(ce), 32'(vecs[v].exp_ce));
      check($sformatf("vec%0d_pending", v), 32'(pending), 32'(vecs[v].exp_pend));
    end
    wr_en = 1'b0;

    // ---- glitch-free update on ch1: 64 running, 128 written mid-period ----
    chan_en = 3'b000;
    write(1, 64);
    tick();
    wr_en   = 1'b0;
    chan_en = 3'b010;
    tick();                                    // E: acc=64
    write(1, 128);
    tick();                                    // E+1: acc=128, parked
    wr_en = 1'b0;
    check("glitch_pend_set", 32'(pending), 32'b010);
    tick();                                    // E+2
    check("glitch_pend_hold", 32'(pending), 32'b010);
    check("glitch_no_early_ce", 32'(ce), 32'b000);
    tick();                                    // E+3: wrap with old inc
    check("glitch_ce_e3", 32'(ce), 32'b010);
    check("glitch_pend_clear", 32'(pending), 32'b000);
    bits = '0;
    for (int k = 0; k < 4; k++) begin          // E+4..E+7: period 2
      tick();
      bits[k] = ce[1];
    end
    check("glitch_new_period", bits, 32'b1010);

    // ---- fractional rate: inc=96 on ch2 -> 3 strobes per 8 clks ----
    chan_en = 3'b000;
    write(2, 96);
    tick();
    wr_en   = 1'b0;
    chan_en = 3'b100;
    bits = '0;
    cnt  = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      bits[k] = ce[2];
      cnt += int'(ce[2]);
    end
    check("frac_pattern", bits, 32'hA4A4);
    check("frac_count", 32'(cnt), 32'd6);

    // ---- double write on ch2: 64 running, 32 then 16 -> only 16 applies ----
    chan_en = 3'b000;
    write(2, 64);
    tick();
    wr_en   = 1'b0;
    chan_en = 3'b100;
    tick();                                    // E
    write(2, 32);
    tick();                                    // E+1
    check("dbl_pend_first", 32'(pending), 32'b100);
    write(2, 16);
    tick();                                    // E+2
    wr_en = 1'b0;
    tick();                                    // E+3: wrap, 16 applied
    check("dbl_ce", 32'(ce), 32'b100);
    check("dbl_pend_clear", 32'(pending), 32'b000);
    gap = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ce[2] && gap == 0) gap = k;
    end
    check("dbl_new_gap", 32'(gap), 32'd16);

    // ---- inc=0 runs 1000 clks with no strobe; out-of-range write mid-run ----
    chan_en = 3'b000;
    write(0, 0);
    tick();
    wr_en   = 1'b0;
    chan_en = 3'b001;
    cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      if (k == 500) write(3, 255);
      tick();
      wr_en = 1'b0;
      cnt += int'(ce[0]);
    end
    check("idle_no_ce", 32'(cnt), 32'd0);
    check("oor_no_pending", 32'(pending), 32'd0);

    // ---- inc=2^ACC_W-1: high except one edge per 256 ----
    chan_en = 3'b000;
    write(0, MOD - 1);
    tick();
    wr_en   = 1'b0;
    chan_en = 3'b001;
    tick();
    check("max_first_low", 32'(ce), 32'd0);
    cnt = 0;
    for (int k = 0; k < MOD - 1; k++) begin
      tick();
      cnt += int'(ce[0]);
    end
    check("max_count", 32'(cnt), 32'(MOD - 1));
    tick();
    check("max_wrap_low", 32'(ce), 32'd0);

    // ---- asynchronous reset mid-operation ----
    chan_en = 3'b011;
    write(1, 10);
    tick();
    wr_en = 1'b0;
    check("prerst_ce", 32'(ce), 32'(m_ce));
    check("prerst_pending", 32'(pending), 32'b010);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_ce", 32'(ce), 32'd0);
    check("rst_async_pending", 32'(pending), 32'd0);
    tick();
    tick();
    check("rst_hold_ce", 32'(ce), 32'd0);
    #3;
    reset_n = 1'b1;
    chan_en = 3'b111;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt += int'(ce != '0) + int'(pending != '0);
    end
    check("postrst_quiet", 32'(cnt), 32'd0);

`ifdef CLK_EN_GEN_SYNC_EN
    // ---- sync: ch0 inc=64, ch1 inc=32, realign both ----
    chan_en = 3'b000;
    write(0, 64);
    tick();
    write(1, 32);
    tick();
    wr_en   = 1'b0;
    chan_en = 3'b011;
    repeat (3) tick();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("sync_edge_no_ce", 32'(ce), 32'd0);
    f0 = 0;
    f1 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ce[0] && f0 == 0) f0 = k;
      if (ce[1] && f1 == 0) f1 = k;
    end
    check("sync_ch0_first", 32'(f0), 32'd4);
    check("sync_ch1_first", 32'(f1), 32'd8);
`else
    f0 = 0;
    f1 = 0;
`endif

    // ---- randomized phase against the reference model ----
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) chan_en = NCHAN'($urandom_range(0, (1 << NCHAN) - 1));
      wr_en   = ($urandom_range(0, 4) == 0);
      wr_chan = CHAN_W'($urandom_range(0, 3));
      wr_data = ACC_W'($urandom_range(0, MOD - 1));
`ifdef CLK_EN_GEN_SYNC_EN
      sync_in = ($urandom_range(0, 49) == 0);
`endif
      tick();
      check($sformatf("rand%0d_ce", c), 32'(ce), 32'(m_ce));
      check($sformatf("rand%0d_pending", c), 32'(pending), 32'(m_pend));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
